hazard_fwd_unit: RTL and testbench

Registered hazard and forwarding controller for the pipelined RV32I core; the successor to the purely combinational EX-stage forwarding selector. It tracks in-flight destination registers through a configurable number of post-EX stages and resolves operand sources while the consumer is still in DE. It delivers registered forward selects aligned with EX, and generates load-use stall, bubble and branch-flush controls. It sits beside the DE/EX pipeline register and is driven by decode-stage fields and the EX branch outcome.

---
 rtl/hazard_pkg.sv | 21 ++
 rtl/fwd_match.sv | 40 ++++
 rtl/hazard_fwd_unit.sv | 135 +++++++++++++
 tb/tb_hazard_fwd_unit.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// Shared hazard/forwarding types: tracker entry, select width, select codes.
// Imported by hazard_fwd_unit and fwd_match.
package hazard_pkg;

  localparam int HZ_AW  = 5;
  localparam int RDY_W  = 3;
  localparam int FWD_RF = 0;
  localparam int FWD_ME = 1;

  typedef struct packed {
    logic             valid;
    logic [HZ_AW-1:0] rd;
    logic             wr;
    logic [RDY_W-1:0] rdy;
  } trk_e_t;

  function automatic int sel_w(input int nfwd);
    return $clog2(nfwd + 1);
  endfunction

endpackage

// File: rtl/fwd_match.sv
// Youngest-match resolver for one source: picks select or flags hazard.
// In: tracker, use_rs, rs. Out: sel (0=RF, k=stage k), hz.
module fwd_match
  import hazard_pkg::*;
#(
  parameter int NFWD   = 2,
  parameter int REG_AW = 5,
  parameter int SEL_W  = 2
) (
  input  trk_e_t            trk [0:NFWD],
  input  logic              use_rs,
  input  logic [REG_AW-1:0] rs,
  output logic [SEL_W-1:0]  sel,
  output logic              hz
);

  logic found;

  always_comb begin
    sel   = SEL_W'(FWD_RF);
    hz    = 1'b0;
    found = 1'b0;
    for (int j = 0; j <= NFWD; j++) begin
      if (!found && use_rs && (rs != '0) &&
          trk[j].valid && trk[j].wr &&
          (trk[j].rd == rs)) begin
        found = 1'b1;
        // WB stage is covered by RF write-through
        if (j == NFWD) begin
          sel = SEL_W'(FWD_RF);
        end else if ((j + 1) < int'(trk[j].rdy)) begin
          hz = 1'b1;
        end else begin
          sel = SEL_W'(FWD_ME + j);
        end
      end
    end
  end

endmodule

// File: rtl/hazard_fwd_unit.sv
// Registered hazard/forwarding controller: tracks post-EX writers, emits
// EX-aligned forward selects, load-use stall and branch flush.
// In: clk, rst_n, freeze, DE fields, br_taken_ex.
// Out: FUAsrc/FUBsrc, stall_fe/de, flush_de/ex.
// HAZARD_PERF_EN adds stall_cnt/flush_cnt.
module hazard_fwd_unit
  import hazard_pkg::*;
#(
  parameter int NFWD     = 2,
  parameter int REG_AW   = 5,
  parameter int LOAD_RDY = 2,
  localparam int SEL_W   = sel_w(NFWD)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              freeze,
  input  logic              valid_de,
  input  logic [REG_AW-1:0] rs1_de,
  input  logic [REG_AW-1:0] rs2_de,
  input  logic              use_rs1_de,
  input  logic              use_rs2_de,
  input  logic [REG_AW-1:0] rd_de,
  input  logic              RUWr_de,
  input  logic              is_load_de,
  input  logic              br_taken_ex,
  output logic [SEL_W-1:0]  FUAsrc,
  output logic [SEL_W-1:0]  FUBsrc,
  output logic              stall_fe,
  output logic              stall_de,
  output logic              flush_de,
`ifdef HAZARD_PERF_EN
  output logic              flush_ex,
  output logic [31:0]       stall_cnt,
  output logic [31:0]       flush_cnt
`else
  output logic              flush_ex
`endif
);

  trk_e_t trk_q [0:NFWD];
  trk_e_t trk_d [0:NFWD];

  logic [SEL_W-1:0] fua_q, fua_d;
  logic [SEL_W-1:0] fub_q, fub_d;
  logic [SEL_W-1:0] sel_a, sel_b;
  logic             hz_a, hz_b, hz;

  fwd_match #(
    .NFWD(NFWD), .REG_AW(REG_AW), .SEL_W(SEL_W)
  ) u_match_a (
    .trk(trk_q), .use_rs(use_rs1_de), .rs(rs1_de),
    .sel(sel_a), .hz(hz_a)
  );

  fwd_match #(
    .NFWD(NFWD), .REG_AW(REG_AW), .SEL_W(SEL_W)
  ) u_match_b (
    .trk(trk_q), .use_rs(use_rs2_de), .rs(rs2_de),
    .sel(sel_b), .hz(hz_b)
  );

  assign hz       = valid_de & (hz_a | hz_b);
  assign flush_de = br_taken_ex;
  assign flush_ex = br_taken_ex | hz;
  assign stall_fe = hz & ~br_taken_ex;
  assign stall_de = hz & ~br_taken_ex;
  assign FUAsrc   = fua_q;
  assign FUBsrc   = fub_q;

  always_comb begin
    trk_d = trk_q;
    fua_d = fua_q;
    fub_d = fub_q;
    if (!freeze) begin
      for (int k = 1; k <= NFWD; k++) begin
        trk_d[k] = trk_q[k-1];
      end
      trk_d[0].valid = valid_de & ~flush_ex;
      trk_d[0].rd    = rd_de;
      trk_d[0].wr    = RUWr_de;
      trk_d[0].rdy   = is_load_de ? RDY_W'(LOAD_RDY)
                                  : RDY_W'(1);
      // bubble or squash enters EX with a RF select
      if (valid_de && !flush_ex) begin
        fua_d = sel_a;
        fub_d = sel_b;
      end else begin
        fua_d = SEL_W'(FWD_RF);
        fub_d = SEL_W'(FWD_RF);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k <= NFWD; k++) begin
        trk_q[k] <= '0;
      end
      fua_q <= '0;
      fub_q <= '0;
    end else begin
      trk_q <= trk_d;
      fua_q <= fua_d;
      fub_q <= fub_d;
    end
  end

`ifdef HAZARD_PERF_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic [31:0] flush_cnt_q, flush_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (!freeze) begin
      if (stall_de) stall_cnt_d = stall_cnt_q + 32'd1;
      if (flush_de) flush_cnt_d = flush_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_hazard_fwd_unit.sv
// Scoreboard bench for hazard_fwd_unit: timestamp-based reference model,
// directed test-plan sequences then random traffic.
module tb_hazard_fwd_unit;

  localparam int NFWD = 2;
  localparam int AW   = 5;
  localparam int LR   = 2;
  localparam int SW   = $clog2(NFWD + 1);

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          freeze = 1'b0;
  logic          valid_de = 1'b0;
  logic [AW-1:0] rs1_de = '0, rs2_de = '0, rd_de = '0;
  logic          use_rs1_de = 1'b0, use_rs2_de = 1'b0;
  logic          RUWr_de = 1'b0, is_load_de = 1'b0;
  logic          br_taken_ex = 1'b0;
  logic [SW-1:0] FUAsrc, FUBsrc;
  logic          stall_fe, stall_de, flush_de, flush_ex;
`ifdef HAZARD_PERF_EN
  logic [31:0]   stall_cnt, flush_cnt;
  int            m_scnt = 0, m_fcnt = 0;
`endif

  hazard_fwd_unit #(
    .NFWD(NFWD), .REG_AW(AW), .LOAD_RDY(LR)
  ) dut (
    .clk(clk), .rst_n(rst_n), .freeze(freeze),
    .valid_de(valid_de),
    .rs1_de(rs1_de), .rs2_de(rs2_de),
    .use_rs1_de(use_rs1_de), .use_rs2_de(use_rs2_de),
    .rd_de(rd_de), .RUWr_de(RUWr_de),
    .is_load_de(is_load_de), .br_taken_ex(br_taken_ex),
    .FUAsrc(FUAsrc), .FUBsrc(FUBsrc),
    .stall_fe(stall_fe), .stall_de(stall_de),
    .flush_de(flush_de),
`ifdef HAZARD_PERF_EN
    .flush_ex(flush_ex),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
`else
    .flush_ex(flush_ex)
`endif
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  function automatic void chk(string nm, int act, int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s act=%0d exp=%0d t=%0t", nm, act, exp, $time);
    end
  endfunction

  // reference model: producers stamped with the cycle they enter EX
  typedef struct {
    logic [AW-1:0] rd;
    int            ex;
    int            rdy;
  } prod_t;

  typedef struct {
    int a, b;
    bit st, fd, fe;
  } rec_t;

  prod_t prods[$];
  rec_t  q[$];
  int    t  = 0;
  int    ma = 0, mb = 0;

  function automatic void resolve(input logic u, input logic [AW-1:0] rs,
                                  output int sel, output bit h);
    int age;
    sel = 0;
    h   = 1'b0;
    if (!u || rs == 0) return;
    for (int i = prods.size() - 1; i >= 0; i--) begin
      if (prods[i].rd == rs) begin
        age = t - prods[i].ex;
        if (age >= NFWD) sel = 0;
        else if (t + 1 < prods[i].ex + prods[i].rdy) h = 1'b1;
        else sel = age + 1;
        return;
      end
    end
  endfunction

  task automatic step(input logic v, input logic [AW-1:0] r1, input logic u1,
                      input logic [AW-1:0] r2, input logic u2,
                      input logic [AW-1:0] rd, input logic wr, input logic ld,
                      input logic br, input logic fz);
    int sa, sb;
    bit ha, hb, h;
    rec_t r;
    @(negedge clk);
    valid_de = v; rs1_de = r1; use_rs1_de = u1;
    rs2_de = r2; use_rs2_de = u2; rd_de = rd;
    RUWr_de = wr; is_load_de = ld; br_taken_ex = br; freeze = fz;
    resolve(u1, r1, sa, ha);
    resolve(u2, r2, sb, hb);
    h = v && (ha || hb);
    r.a = ma; r.b = mb;
    r.st = h && !br; r.fd = br; r.fe = h || br;
    q.push_back(r);
    @(posedge clk);
    if (!fz) begin
`ifdef HAZARD_PERF_EN
      if (r.st) m_scnt++;
      if (r.fd) m_fcnt++;
`endif
      ma = (v && !r.fe) ? sa : 0;
      mb = (v && !r.fe) ? sb : 0;
      if (v && !r.fe && wr && rd != 0)
        prods.push_back('{rd: rd, ex: t + 1, rdy: ld ? LR : 1});
      t++;
      while (prods.size() > 0 && t - prods[0].ex > NFWD)
        void'(prods.pop_front());
    end
  endtask

  task automatic ins(input logic [AW-1:0] rd, input logic wr, input logic ld,
                     input logic [AW-1:0] r1, input logic u1,
                     input logic [AW-1:0] r2, input logic u2);
    step(1, r1, u1, r2, u2, rd, wr, ld, 0, 0);
  endtask

  task automatic nops(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // monitor: compares every presented cycle against the queued expectation
  initial begin
    rec_t r;
    forever begin
      @(negedge clk);
      #3;
      if (q.size() > 0) begin
        r = q.pop_front();
        chk("fua", int'(FUAsrc), r.a);
        chk("fub", int'(FUBsrc), r.b);
        chk("stall_fe", int'(stall_fe), int'(r.st));
        chk("stall_de", int'(stall_de), int'(r.st));
        chk("flush_de", int'(flush_de), int'(r.fd));
        chk("flush_ex", int'(flush_ex), int'(r.fe));
      end
    end
  end

  initial begin
    #1 rst_n = 1'b0;
    #2;
    chk("rst_fua", int'(FUAsrc), 0);
    chk("rst_fub", int'(FUBsrc), 0);
    chk("rst_stall", int'(stall_de), 0);
    chk("rst_flush", int'(flush_ex), 0);
    #9 rst_n = 1'b1;
    nops(2);
    // ALU producer then immediate consumer
    ins(5, 1, 0, 0, 0, 0, 0);
    ins(0, 0, 0, 5, 1, 0, 0);
    nops(3);
    // distance 2 on rs2
    ins(5, 1, 0, 0, 0, 0, 0);
    ins(9, 1, 0, 1, 1, 2, 1);
    ins(0, 0, 0, 0, 0, 5, 1);
    nops(3);
    // load-use: one stall, consumer held in DE
    ins(7, 1, 1, 0, 0, 0, 0);
    ins(0, 0, 0, 7, 1, 0, 0);
    ins(0, 0, 0, 7, 1, 0, 0);
    nops(3);
    // youngest wins
    ins(3, 1, 0, 0, 0, 0, 0);
    ins(3, 1, 0, 0, 0, 0, 0);
    ins(0, 0, 0, 3, 1, 3, 1);
    nops(3);
    // x0, non-writer, unused source
    ins(0, 1, 0, 0, 0, 0, 0);
    ins(0, 0, 0, 0, 1, 0, 1);
    ins(4, 0, 0, 0, 0, 0, 0);
    ins(0, 0, 0, 4, 1, 4, 1);
    ins(6, 1, 0, 0, 0, 0, 0);
    ins(0, 0, 0, 6, 0, 6, 0);
    nops(3);
    // load-use with branch in same cycle
    ins(8, 1, 1, 0, 0, 0, 0);
    step(1, 8, 1, 0, 0, 0, 0, 0, 1, 0);
    ins(0, 0, 0, 8, 1, 8, 1);
    nops(3);
    // freeze mid-sequence
    ins(5, 1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) step(1, 5, 1, 5, 1, 2, 1, 0, 0, 1);
    ins(0, 0, 0, 5, 1, 5, 1);
    nops(3);
    // random traffic
    for (int i = 0; i < 600; i++) begin
      step($urandom_range(0, 9) != 0,
           AW'($urandom_range(0, 7)), $urandom_range(0, 3) != 0,
           AW'($urandom_range(0, 7)), $urandom_range(0, 3) != 0,
           AW'($urandom_range(0, 7)), $urandom_range(0, 4) != 0,
           $urandom_range(0, 2) == 0,
           $urandom_range(0, 11) == 0,
           $urandom_range(0, 9) == 0);
    end
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
    chk("drain", q.size(), 0);
`ifdef HAZARD_PERF_EN
    chk("stall_cnt", int'(stall_cnt), m_scnt);
    chk("flush_cnt", int'(flush_cnt), m_fcnt);
`endif
    // async reset in the middle of a load-use stall
    @(negedge clk);
    valid_de = 1; rd_de = 9; RUWr_de = 1; is_load_de = 1;
    use_rs1_de = 0; use_rs2_de = 0; br_taken_ex = 0; freeze = 0;
    @(negedge clk);
    rd_de = 0; RUWr_de = 0; is_load_de = 0;
    rs1_de = 9; use_rs1_de = 1;
    #1;
    chk("pre_rst_stall", int'(stall_de), 1);
    rst_n = 1'b0;
    #1;
    chk("async_stall_fe", int'(stall_fe), 0);
    chk("async_stall_de", int'(stall_de), 0);
    chk("async_flush_ex", int'(flush_ex), 0);
    chk("async_fua", int'(FUAsrc), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
